// File: rtl/bb_reset_sequencer_if.sv
// Signal bundle between the reset sequencer and the sub-blocks it releases.
// The master side is the sequencer; the slave side is the set of sub-blocks.
interface bb_reset_sequencer_if #(
    parameter int STAGE_NUM = 4
);
    logic                 sw_rst_req;
    logic [STAGE_NUM-1:0] stage_ack;
    logic [STAGE_NUM-1:0] stage_rst_n;
    logic                 seq_busy;
    logic                 seq_done;
    logic [STAGE_NUM-1:0] ack_err;

    modport master (
        input  sw_rst_req,
        input  stage_ack,
        output stage_rst_n,
        output seq_busy,
        output seq_done,
        output ack_err
    );

    modport slave (
        output sw_rst_req,
        output stage_ack,
        input  stage_rst_n,
        input  seq_busy,
        input  seq_done,
        input  ack_err
    );
endinterface

// File: rtl/bb_reset_sequencer.sv
// Staged reset-release sequencer: hold all sub-block resets, then release them
// one at a time with a fixed gap and an acknowledge wait bounded by a timeout.
module bb_reset_sequencer #(
    parameter int STAGE_NUM   = 4,
    parameter int HOLD_CYC    = 8,
    parameter int GAP_CYC     = 16,
    parameter int ACK_TIMEOUT = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bb_reset_sequencer_if.master   bus
);

    localparam int MAX_HG  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int MAX_CYC = (MAX_HG > ACK_TIMEOUT) ? MAX_HG : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(STAGE_NUM - 1);

    typedef enum logic [1:0] {
        HOLD,
        GAP,
        ACK,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [STAGE_NUM-1:0] rst_q, rst_d;
    logic [STAGE_NUM-1:0] err_q, err_d;
    logic                 done_q, done_d;

    // Shift instead of bit-select so a one-stage build never indexes past bit 0.
    logic [STAGE_NUM-1:0] ack_shift;
    logic [STAGE_NUM-1:0] idx_mask;
    logic                 ack_cur;

    assign ack_shift = bus.stage_ack >> idx_q;
    assign ack_cur   = ack_shift[0];
    assign idx_mask  = STAGE_NUM'(1) << idx_q;

    // NOTE: every signal gets its default before the case statement, so no
    // path through this block can leave a value unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        err_d   = err_q;
        done_d  = done_q;

        unique case (state_q)
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    rst_d   = rst_q | idx_mask;
                    state_d = ACK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ACK: begin
                // An acknowledge on the timeout edge still counts as success.
                if (ack_cur || (cnt_q == ACK_LAST)) begin
                    if (!ack_cur) begin
                        err_d = err_q | idx_mask;
                    end
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = GAP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                if (bus.sw_rst_req) begin
                    rst_d   = '0;
                    done_d  = 1'b0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end

            default: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign bus.stage_rst_n = rst_q;
    assign bus.ack_err     = err_q;
    assign bus.seq_done    = done_q;
    assign bus.seq_busy    = (state_q != DONE);

endmodule

// File: tb/tb_bb_reset_sequencer.sv
// Bench for bb_reset_sequencer: scenario table drives acknowledges and requests,
// an event scoreboard checks the edge and value of every output change.
module tb_bb_reset_sequencer;

    typedef struct {
        int         dut;
        logic [3:0] ack0;
        int         ack_chg_at;
        logic [3:0] ack1;
        int         sw_at [3];
        int         rst_low_at;
    } scen_t;

    typedef struct {
        int         scen;
        int         at;
        logic [3:0] rst;
        logic       done;
        logic [3:0] err;
    } ev_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] ack   = 4'b0000;
    logic       sw    = 1'b0;
    int         sel   = 0;

    int n_cmp  = 0;
    int n_fail = 0;
    int cur_scen = 0;

    scen_t scen_tab [5];
    ev_t   ev_tab [$];
    ev_t   sb [$];

    logic [3:0] obs_rst, obs_err, prev_rst, prev_err;
    logic       obs_done, obs_busy, prev_done, exp_done;

    always #5 clk = ~clk;

    bb_reset_sequencer_if #(.STAGE_NUM(4)) bus_a ();
    bb_reset_sequencer_if #(.STAGE_NUM(2)) bus_b ();
    bb_reset_sequencer_if #(.STAGE_NUM(1)) bus_c ();

    assign bus_a.stage_ack  = ack;
    assign bus_b.stage_ack  = ack[1:0];
    assign bus_c.stage_ack  = ack[0:0];
    assign bus_a.sw_rst_req = sw && (sel == 0);
    assign bus_b.sw_rst_req = sw && (sel == 1);
    assign bus_c.sw_rst_req = sw && (sel == 2);

    bb_reset_sequencer dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.master)
    );

    bb_reset_sequencer #(
        .STAGE_NUM   (2),
        .HOLD_CYC    (2),
        .GAP_CYC     (2),
        .ACK_TIMEOUT (4)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.master)
    );

    bb_reset_sequencer #(
        .STAGE_NUM   (1),
        .HOLD_CYC    (1),
        .GAP_CYC     (1),
        .ACK_TIMEOUT (4)
    ) dut_c (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_c.master)
    );

    always_comb begin
        obs_rst  = 4'b0000;
        obs_err  = 4'b0000;
        obs_done = 1'b0;
        obs_busy = 1'b0;
        case (sel)
            0: begin
                obs_rst  = bus_a.stage_rst_n;
                obs_err  = bus_a.ack_err;
                obs_done = bus_a.seq_done;
                obs_busy = bus_a.seq_busy;
            end
            1: begin
                obs_rst  = {2'b00, bus_b.stage_rst_n};
                obs_err  = {2'b00, bus_b.ack_err};
                obs_done = bus_b.seq_done;
                obs_busy = bus_b.seq_busy;
            end
            default: begin
                obs_rst  = {3'b000, bus_c.stage_rst_n};
                obs_err  = {3'b000, bus_c.ack_err};
                obs_done = bus_c.seq_done;
                obs_busy = bus_c.seq_busy;
            end
        endcase
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL scen%0d %s: got %0h, want %0h", cur_scen, name, got, want);
        end
    endtask

    task automatic set_scen(input int s, input int dut, input logic [3:0] ack0,
                            input int chg, input logic [3:0] ack1,
                            input int sw0, input int sw1, input int sw2, input int rlow);
        scen_tab[s].dut        = dut;
        scen_tab[s].ack0       = ack0;
        scen_tab[s].ack_chg_at = chg;
        scen_tab[s].ack1       = ack1;
        scen_tab[s].sw_at[0]   = sw0;
        scen_tab[s].sw_at[1]   = sw1;
        scen_tab[s].sw_at[2]   = sw2;
        scen_tab[s].rst_low_at = rlow;
    endtask

    task automatic add_ev(input int s, input int at, input logic [3:0] r,
                          input logic d, input logic [3:0] e);
        ev_t x;
        x.scen = s;
        x.at   = at;
        x.rst  = r;
        x.done = d;
        x.err  = e;
        ev_tab.push_back(x);
    endtask

    // Called after each edge (and after an async reset); pops one event per change.
    task automatic step(input int e);
        ev_t x;
        if (obs_rst !== prev_rst || obs_done !== prev_done || obs_err !== prev_err) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL scen%0d unexpected_change edge %0d: rst=%b done=%b err=%b, want no change",
                         cur_scen, e, obs_rst, obs_done, obs_err);
            end else begin
                x = sb.pop_front();
                check("ev_edge", e, x.at);
                check("ev_stage_rst_n", {28'd0, obs_rst}, {28'd0, x.rst});
                check("ev_seq_done", {31'd0, obs_done}, {31'd0, x.done});
                check("ev_ack_err", {28'd0, obs_err}, {28'd0, x.err});
                exp_done = x.done;
            end
        end
        check("seq_busy", {31'd0, obs_busy}, {31'd0, ~exp_done});
        prev_rst  = obs_rst;
        prev_done = obs_done;
        prev_err  = obs_err;
    endtask

    task automatic run_scen(input int s);
        scen_t sc;
        int    e;
        int    tot;
        int    idle;
        bit    restarted;
        sc        = scen_tab[s];
        cur_scen  = s;
        sel       = sc.dut;
        rst_n     = 1'b0;
        sw        = 1'b0;
        ack       = sc.ack0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_stage_rst_n", {28'd0, obs_rst}, 32'd0);
        check("reset_seq_done", {31'd0, obs_done}, 32'd0);
        check("reset_ack_err", {28'd0, obs_err}, 32'd0);
        check("reset_seq_busy", {31'd0, obs_busy}, 32'd1);
        prev_rst  = obs_rst;
        prev_done = obs_done;
        prev_err  = obs_err;
        exp_done  = 1'b0;
        sb.delete();
        foreach (ev_tab[k]) begin
            if (ev_tab[k].scen == s) sb.push_back(ev_tab[k]);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        e         = 0;
        tot       = 0;
        idle      = 0;
        restarted = 1'b0;
        while (tot < 2000 && idle < 20) begin
            @(posedge clk);
            #1;
            e++;
            tot++;
            step(e);
            idle = (sb.size() == 0) ? idle + 1 : 0;
            sw   = 1'b0;
            if (!restarted) begin
                if (e == sc.ack_chg_at) ack = sc.ack1;
                for (int k = 0; k < 3; k++) begin
                    if (sc.sw_at[k] == e + 1) sw = 1'b1;
                end
                if (e == sc.rst_low_at) begin
                    rst_n = 1'b0;
                    #1;
                    step(e);
                    restarted = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    rst_n = 1'b1;
                    e     = 0;
                end
            end
        end
        check("events_left", sb.size(), 32'd0);
    endtask

    initial begin
        // dut, ack0, ack change edge, ack1, sw pulses, rst_n-low edge
        set_scen(0, 0, 4'b1111, 0,   4'b1111, 0,  0,   0,   0);
        set_scen(1, 0, 4'b1011, 335, 4'b1111, 30, 100, 340, 390);
        set_scen(2, 0, 4'b1101, 46,  4'b1111, 0,  0,   0,   0);
        set_scen(3, 1, 4'b0000, 7,   4'b0001, 0,  0,   0,   0);
        set_scen(4, 2, 4'b0000, 5,   4'b0001, 8,  0,   0,   0);

        // Power-up, all acks high.
        add_ev(0, 24, 4'b0001, 1'b0, 4'b0000);
        add_ev(0, 41, 4'b0011, 1'b0, 4'b0000);
        add_ev(0, 58, 4'b0111, 1'b0, 4'b0000);
        add_ev(0, 75, 4'b1111, 1'b0, 4'b0000);
        add_ev(0, 76, 4'b1111, 1'b1, 4'b0000);
        // Stage 2 timeout, ignored requests, re-sequence, then reset mid-run.
        add_ev(1, 24,  4'b0001, 1'b0, 4'b0000);
        add_ev(1, 41,  4'b0011, 1'b0, 4'b0000);
        add_ev(1, 58,  4'b0111, 1'b0, 4'b0000);
        add_ev(1, 314, 4'b0111, 1'b0, 4'b0100);
        add_ev(1, 330, 4'b1111, 1'b0, 4'b0100);
        add_ev(1, 331, 4'b1111, 1'b1, 4'b0100);
        add_ev(1, 340, 4'b0000, 1'b0, 4'b0100);
        add_ev(1, 364, 4'b0001, 1'b0, 4'b0100);
        add_ev(1, 381, 4'b0011, 1'b0, 4'b0100);
        add_ev(1, 390, 4'b0000, 1'b0, 4'b0000);
        add_ev(1, 24,  4'b0001, 1'b0, 4'b0000);
        add_ev(1, 41,  4'b0011, 1'b0, 4'b0000);
        add_ev(1, 58,  4'b0111, 1'b0, 4'b0000);
        add_ev(1, 75,  4'b1111, 1'b0, 4'b0000);
        add_ev(1, 76,  4'b1111, 1'b1, 4'b0000);
        // Late ack on stage 1, sampled at edge 47.
        add_ev(2, 24, 4'b0001, 1'b0, 4'b0000);
        add_ev(2, 41, 4'b0011, 1'b0, 4'b0000);
        add_ev(2, 63, 4'b0111, 1'b0, 4'b0000);
        add_ev(2, 80, 4'b1111, 1'b0, 4'b0000);
        add_ev(2, 81, 4'b1111, 1'b1, 4'b0000);
        // ACK_TIMEOUT=4: stage 0 acked on the timeout edge, stage 1 times out.
        add_ev(3, 4,  4'b0001, 1'b0, 4'b0000);
        add_ev(3, 10, 4'b0011, 1'b0, 4'b0000);
        add_ev(3, 14, 4'b0011, 1'b1, 4'b0010);
        // One stage, minimum hold/gap: boundary ack, then re-sequence.
        add_ev(4, 2,  4'b0001, 1'b0, 4'b0000);
        add_ev(4, 6,  4'b0001, 1'b1, 4'b0000);
        add_ev(4, 8,  4'b0000, 1'b0, 4'b0000);
        add_ev(4, 10, 4'b0001, 1'b0, 4'b0000);
        add_ev(4, 11, 4'b0001, 1'b1, 4'b0000);

        for (int s = 0; s < 5; s++) begin
            run_scen(s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
